x_front_to_front_fifo: RTL and testbench
========================================

Name: x_front_to_front_fifo

Overview:
- Parametrised successor to the single-entry UART loopback.
- Receives bytes on i_rx through x_uart_rx, applies a runtime-selectable byte transform, buffers them in a p_depth-entry FIFO, and retransmits them through x_uart_tx.
- Absorbs bursts of back-to-back received bytes without loss, up to p_depth entries.
- Reports fill level and a sticky overflow flag for a host/debug bus.

Parameters:
- p_clk_hz, 12000000, system clock frequency in Hz; passed to both UART sub-blocks.
- p_baud, 115200, line baud rate; passed to both UART sub-blocks.
- p_depth, 8, FIFO entries; power of two, range 2..256.

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset. Sub-blocks receive ~i_rst_n on their active-high i_rst.
- i_rx  in  1  serial receive line, idle high.
- o_tx  out  1  serial transmit line, idle high.
- i_mode  in  2  transform select, sampled at push time.
- i_clr_ovf  in  1  single-cycle pulse; clears o_overflow.
- o_level  out  $clog2(p_depth)+1  current FIFO occupancy, 0..p_depth.
- o_full  out  1  o_level == p_depth.
- o_overflow  out  1  sticky; set when a received byte is dropped.

Behaviour:
- Reset (async assert, sync-safe deassert via the flop reset):
  - rd_ptr = wr_ptr = 0, o_level = 0, o_full = 0, o_overflow = 0.
  - FIFO contents don't-care.
  - o_tx = 1 (tx sub-block idle).
  - Any byte in flight in either UART is abandoned; no partial frame is resent after reset.
- Transform, applied combinationally to rx o_data in the push cycle; the transformed value is stored:
  - mode 0: pass through.
  - mode 1: bitwise invert.
  - mode 2: data + 1, modulo 256 (0xFF -> 0x00).
  - mode 3: ASCII uppercase. 0x61..0x7A -> minus 0x20; all other values unchanged.
  - Changing i_mode never alters bytes already queued.
- Push: occurs in the cycle rx_valid = 1 and (!o_full or pop in the same cycle).
  - Write mem[wr_ptr]; wr_ptr increments, wrapping modulo p_depth.
- Drop: rx_valid = 1 while o_full and no pop that cycle.
  - Byte discarded; pointers unchanged.
  - o_overflow <= 1 on the next edge.
- Pop / tx handshake:
  - tx i_valid = (o_level != 0); tx i_data = mem[rd_ptr] (show-ahead).
  - Transfer happens in a cycle where tx i_valid and o_accept are both 1; rd_ptr increments and wraps.
  - tx i_data must hold stable while i_valid = 1 and o_accept = 0.
- Level:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
  - neither: unchanged.
  - Never exceeds p_depth; never underflows.
- o_overflow:
  - If i_clr_ovf and a drop occur in the same cycle, set wins (flag stays 1).
  - Otherwise i_clr_ovf clears it on the next edge.
- Latency:
  - Empty FIFO: push at cycle N gives tx i_valid = 1 at N+1.
  - Start bit appears on o_tx per the x_uart_tx timing after accept.
- Ordering: strict FIFO; bytes leave in arrival order, with no duplication and no reordering.
- Empty with no rx: tx i_valid = 0, o_tx stays high indefinitely.

Test Plan:
- Reset then idle 2000 cycles -> o_tx = 1, o_level = 0, o_full = 0, o_overflow = 0 throughout.
- mode 0, send 0x55, 0xA3, 0x00 serially at 115200 -> o_tx emits 0x55, 0xA3, 0x00 in order; o_level peaks at 1 or 2 and returns to 0.
- Transform check, one byte per mode:
  - mode 1: 0x0F -> 0xF0.
  - mode 2: 0xFF -> 0x00.
  - mode 3: 0x61 -> 0x41 and 0x5B -> 0x5B.
  - Switching mode while a byte is queued leaves that byte unchanged.
- p_depth = 4, rx at 115200 and tx built at p_baud/2 (separate tx instance via test override), send 0x10..0x19 back-to-back:
  - o_full asserts.
  - o_overflow rises on the first dropped byte.
  - Output sequence is an in-order prefix-preserving subset with no duplicates.
  - o_level never exceeds 4.
- With the FIFO full, force rx_valid and tx accept in the same cycle -> push accepted, o_level stays 4, o_overflow not set. Then pulse i_clr_ovf -> o_overflow returns to 0; a simultaneous drop plus clear -> o_overflow stays 1.
- Assert i_rst_n low mid-frame with 3 bytes queued -> o_tx = 1 and o_level = 0 immediately (async). After release, a new byte 0x7E loops back cleanly.

Source files
------------

// File: rtl/x_front_to_front_fifo.sv
// UART front-to-front loopback: received bytes are transformed, buffered in a
// p_depth-entry FIFO and retransmitted. Contains the rx/tx UART sub-blocks.

module x_uart_rx #(
  parameter int p_clk_hz = 12000000,
  parameter int p_baud   = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid
);
  localparam int CPB = p_clk_hz / p_baud;
  localparam int CW  = $clog2(CPB + 1);
  localparam logic [CW-1:0] CNT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t       state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic            rx_s0, rx_s1;
  logic [7:0]      shreg;
  logic            bit_tick, stop_tick;

  assign bit_tick  = (state == RX_DATA) && (cnt == CNT_END);
  assign stop_tick = (state == RX_STOP) && (cnt == CNT_END);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      rx_s0   <= 1'b1;
      rx_s1   <= 1'b1;
      o_valid <= 1'b0;
    end else begin
      rx_s0   <= i_rx;
      rx_s1   <= rx_s0;
      o_valid <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s1) state <= RX_START;
        end
        RX_START: begin
          // Re-check the line at mid start bit to reject glitches.
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            state <= rx_s1 ? RX_IDLE : RX_DATA;
          end else cnt <= cnt + CW'(1);
        end
        RX_DATA: begin
          if (cnt == CNT_END) begin
            cnt <= '0;
            if (bit_idx == 3'd7) state <= RX_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else cnt <= cnt + CW'(1);
        end
        RX_STOP: begin
          if (cnt == CNT_END) begin
            state   <= RX_IDLE;
            o_valid <= rx_s1;
          end else cnt <= cnt + CW'(1);
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (bit_tick)  shreg  <= {rx_s1, shreg[7:1]};
    if (stop_tick) o_data <= shreg;
  end
endmodule

module x_uart_tx #(
  parameter int p_clk_hz = 12000000,
  parameter int p_baud   = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_accept,
  output logic       o_tx
);
  localparam int CPB = p_clk_hz / p_baud;
  localparam int CW  = $clog2(CPB + 1);
  localparam logic [CW-1:0] CNT_END = CW'(CPB - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign o_accept = (state == TX_IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      o_tx    <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          o_tx    <= 1'b1;
          if (i_valid) begin
            o_tx  <= 1'b0;
            state <= TX_START;
          end
        end
        TX_START: begin
          if (cnt == CNT_END) begin
            cnt   <= '0;
            o_tx  <= shreg[0];
            state <= TX_DATA;
          end else cnt <= cnt + CW'(1);
        end
        TX_DATA: begin
          if (cnt == CNT_END) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              o_tx  <= 1'b1;
              state <= TX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              o_tx    <= shreg[1];
            end
          end else cnt <= cnt + CW'(1);
        end
        TX_STOP: begin
          if (cnt == CNT_END) state <= TX_IDLE;
          else cnt <= cnt + CW'(1);
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (state == TX_IDLE && i_valid) shreg <= i_data;
    else if (state == TX_DATA && cnt == CNT_END) shreg <= {1'b0, shreg[7:1]};
  end
endmodule

module x_front_to_front_fifo #(
  parameter int p_clk_hz  = 12000000,
  parameter int p_baud    = 115200,
  parameter int p_depth   = 8,
  parameter int p_tx_baud = p_baud
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_rx,
  output logic                      o_tx,
  input  logic [1:0]                i_mode,
  input  logic                      i_clr_ovf,
  output logic [$clog2(p_depth):0]  o_level,
  output logic                      o_full,
  output logic                      o_overflow
);
  localparam int AW = $clog2(p_depth);
  localparam int LW = AW + 1;

  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_accept;
  logic          push, pop, drop;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    mem [p_depth];

  function automatic logic [7:0] xform(input logic [1:0] mode, input logic [7:0] d);
    logic [7:0] r;
    r = d;
    case (mode)
      2'd1:    r = ~d;
      2'd2:    r = d + 8'd1;
      2'd3:    r = (d >= 8'h61 && d <= 8'h7A) ? d - 8'h20 : d;
      default: r = d;
    endcase
    return r;
  endfunction

  assign rst = ~i_rst_n;

  x_uart_rx #(.p_clk_hz(p_clk_hz), .p_baud(p_baud)) u_rx (
    .i_clk  (i_clk),
    .i_rst  (rst),
    .i_rx   (i_rx),
    .o_data (rx_data),
    .o_valid(rx_valid)
  );

  x_uart_tx #(.p_clk_hz(p_clk_hz), .p_baud(p_tx_baud)) u_tx (
    .i_clk   (i_clk),
    .i_rst   (rst),
    .i_valid (tx_valid),
    .i_data  (tx_data),
    .o_accept(tx_accept),
    .o_tx    (o_tx)
  );

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign o_full   = (o_level == LW'(p_depth));
  assign tx_valid = (o_level != '0);
  assign tx_data  = mem[rd_ptr];
  assign pop      = tx_valid & tx_accept;
  assign push     = rx_valid & (~o_full | pop);
  assign drop     = rx_valid & o_full & ~pop;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= xform(i_mode, rx_data);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_level    <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   o_level <= o_level + LW'(1);
        2'b01:   o_level <= o_level - LW'(1);
        default: o_level <= o_level;
      endcase
      if (drop)           o_overflow <= 1'b1;
      else if (i_clr_ovf) o_overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_x_front_to_front_fifo.sv
// Bench for x_front_to_front_fifo: serial stimulus, serial decode monitor and
// expected/observed byte queues, plus forced handshakes for the full-FIFO corner.

module tb_x_front_to_front_fifo;
  localparam int CPB_RX = 10;
  localparam int CPB_TX = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       tx;
  logic [1:0] mode = 2'd0;
  logic       clr_ovf = 1'b0;
  logic [2:0] level;
  logic       full;
  logic       ovf;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] expq[$];
  logic [7:0] obs[$];
  bit         mon_en = 1'b0;

  int  max_level = 0;
  bit  saw_full = 1'b0;
  bit  ovf_early = 1'b0;

  x_front_to_front_fifo #(
    .p_clk_hz (1152000),
    .p_baud   (115200),
    .p_depth  (4),
    .p_tx_baud(57600)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_rx      (rx),
    .o_tx      (tx),
    .i_mode    (mode),
    .i_clr_ovf (clr_ovf),
    .o_level   (level),
    .o_full    (full),
    .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Serial decoder on o_tx; abandons a frame if reset is seen.
  initial begin : monitor
    bit ok;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && tx === 1'b0) begin
        ok = 1'b1;
        b  = '0;
        repeat (CPB_TX / 2) begin @(negedge clk); if (!rst_n) ok = 1'b0; end
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB_TX) begin @(negedge clk); if (!rst_n) ok = 1'b0; end
          b[i] = tx;
        end
        repeat (CPB_TX) begin @(negedge clk); if (!rst_n) ok = 1'b0; end
        if (tx !== 1'b1) ok = 1'b0;
        if (ok) obs.push_back(b);
      end
    end
  end

  initial begin : tracker
    forever begin
      @(negedge clk);
      if (int'(level) > max_level) max_level = int'(level);
      if (full === 1'b1) saw_full = 1'b1;
      if (ovf === 1'b1 && !saw_full) ovf_early = 1'b1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB_RX) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB_RX) @(negedge clk);
    end
    rx = 1'b1;
    repeat (CPB_RX) @(negedge clk);
  endtask

  task automatic wait_obs(output logic [7:0] b, output bit got);
    got = 1'b0;
    b   = '0;
    for (int i = 0; i < 1500; i++) begin
      if (obs.size() > 0) begin
        b   = obs.pop_front();
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (tx !== 1'b1 || level !== 3'd0 || full !== 1'b0 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hold: tx=%b level=%0d full=%b ovf=%b, required 1/0/0/0", tx, level, full, ovf);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (tx !== 1'b1 || level !== 3'd0 || full !== 1'b0 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: tx=%b level=%0d full=%b ovf=%b, required 1/0/0/0", tx, level, full, ovf);
    end
  endtask

  task automatic test_idle();
    int bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || level !== 3'd0 || full !== 1'b0 || ovf !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL idle: %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_basic();
    logic [7:0] b;
    bit got;
    logic [7:0] seq [3];
    seq[0] = 8'h55; seq[1] = 8'hA3; seq[2] = 8'h00;
    mode = 2'd0;
    mon_en = 1'b1;
    max_level = 0;
    for (int i = 0; i < 3; i++) begin
      expq.push_back(seq[i]);
      send_byte(seq[i]);
    end
    for (int i = 0; i < 3; i++) begin
      wait_obs(b, got);
      tests_run++;
      if (!got || b !== expq[0]) begin
        tests_failed++;
        $display("FAIL basic_byte%0d: got %h (seen=%0d), required %h", i, b, got, expq[0]);
      end
      void'(expq.pop_front());
    end
    tests_run++;
    if (max_level < 1 || max_level > 2 || level !== 3'd0) begin
      tests_failed++;
      $display("FAIL basic_level: peak %0d final %0d, required peak 1..2 final 0", max_level, level);
    end
  endtask

  task automatic test_transform();
    logic [7:0] b;
    bit got;
    logic [1:0] tm [9];
    logic [7:0] ti [9];
    logic [7:0] te [9];
    tm[0]=2'd1; ti[0]=8'h0F; te[0]=8'hF0;
    tm[1]=2'd2; ti[1]=8'hFF; te[1]=8'h00;
    tm[2]=2'd3; ti[2]=8'h61; te[2]=8'h41;
    tm[3]=2'd3; ti[3]=8'h5B; te[3]=8'h5B;
    tm[4]=2'd3; ti[4]=8'h7A; te[4]=8'h5A;
    tm[5]=2'd3; ti[5]=8'h60; te[5]=8'h60;
    tm[6]=2'd2; ti[6]=8'h41; te[6]=8'h42;
    tm[7]=2'd1; ti[7]=8'h00; te[7]=8'hFF;
    tm[8]=2'd0; ti[8]=8'hC3; te[8]=8'hC3;
    for (int i = 0; i < 9; i++) begin
      mode = tm[i];
      expq.push_back(te[i]);
      send_byte(ti[i]);
      wait_obs(b, got);
      tests_run++;
      if (!got || b !== expq[0]) begin
        tests_failed++;
        $display("FAIL xform_m%0d_%h: got %h (seen=%0d), required %h", tm[i], ti[i], b, got, expq[0]);
      end
      void'(expq.pop_front());
    end
  endtask

  task automatic test_mode_switch();
    logic [7:0] b;
    bit got;
    mode = 2'd3;
    expq.push_back(8'h41); send_byte(8'h61);
    expq.push_back(8'h42); send_byte(8'h62);
    repeat (5) @(negedge clk);
    mode = 2'd0;
    tests_run++;
    if (level !== 3'd1) begin
      tests_failed++;
      $display("FAIL switch_queued_level: got %0d, required 1", level);
    end
    expq.push_back(8'h63); send_byte(8'h63);
    for (int i = 0; i < 3; i++) begin
      wait_obs(b, got);
      tests_run++;
      if (!got || b !== expq[0]) begin
        tests_failed++;
        $display("FAIL switch_byte%0d: got %h (seen=%0d), required %h", i, b, got, expq[0]);
      end
      void'(expq.pop_front());
    end
  endtask

  task automatic test_burst();
    bit drained = 1'b0;
    bit order_ok = 1'b1;
    int n;
    logic [7:0] b;
    mode = 2'd0;
    max_level = 0; saw_full = 1'b0; ovf_early = 1'b0;
    for (int i = 0; i < 10; i++) begin
      expq.push_back(8'h10 + 8'(i));
      send_byte(8'h10 + 8'(i));
    end
    for (int i = 0; i < 3000; i++) begin
      if (level === 3'd0) begin drained = 1'b1; break; end
      @(negedge clk);
    end
    repeat (250) @(negedge clk);
    tests_run++;
    if (!drained) begin
      tests_failed++;
      $display("FAIL burst_drain: level %0d after budget, required 0", level);
    end
    tests_run++;
    if (!saw_full || max_level > 4) begin
      tests_failed++;
      $display("FAIL burst_full: saw_full=%0d peak=%0d, required 1 and <=4", saw_full, max_level);
    end
    tests_run++;
    if (ovf !== 1'b1 || ovf_early) begin
      tests_failed++;
      $display("FAIL burst_overflow: ovf=%b early=%0d, required 1 and 0", ovf, ovf_early);
    end
    n = obs.size();
    while (obs.size() > 0) begin
      b = obs.pop_front();
      while (expq.size() > 0 && expq[0] !== b) void'(expq.pop_front());
      if (expq.size() == 0) order_ok = 1'b0;
      else void'(expq.pop_front());
    end
    expq.delete();
    tests_run++;
    if (!order_ok || n < 5 || n > 9) begin
      tests_failed++;
      $display("FAIL burst_order: in_order=%0d count=%0d, required 1 and 5..9", order_ok, n);
    end
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    tests_run++;
    if (ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL burst_clear: ovf=%b, required 0", ovf);
    end
  endtask

  task automatic test_full_corner();
    mon_en = 1'b0;
    do_reset();
    force dut.tx_accept = 1'b0;
    force dut.rx_valid  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      force dut.rx_data  = 8'hA0 + 8'(i);
      force dut.rx_valid = 1'b1;
      @(negedge clk);
      force dut.rx_valid = 1'b0;
    end
    @(negedge clk);
    tests_run++;
    if (level !== 3'd4 || full !== 1'b1 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL corner_fill: level=%0d full=%b ovf=%b, required 4/1/0", level, full, ovf);
    end
    force dut.rx_valid  = 1'b1;
    force dut.tx_accept = 1'b1;
    @(negedge clk);
    force dut.rx_valid  = 1'b0;
    force dut.tx_accept = 1'b0;
    tests_run++;
    if (level !== 3'd4 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL corner_push_pop: level=%0d ovf=%b, required 4/0", level, ovf);
    end
    force dut.rx_valid = 1'b1;
    @(negedge clk);
    force dut.rx_valid = 1'b0;
    tests_run++;
    if (level !== 3'd4 || ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL corner_drop: level=%0d ovf=%b, required 4/1", level, ovf);
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    tests_run++;
    if (ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL corner_clear: ovf=%b, required 0", ovf);
    end
    force dut.rx_valid = 1'b1;
    clr_ovf = 1'b1;
    @(negedge clk);
    force dut.rx_valid = 1'b0;
    clr_ovf = 1'b0;
    tests_run++;
    if (ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL corner_drop_and_clear: ovf=%b, required 1", ovf);
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    tests_run++;
    if (ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL corner_clear2: ovf=%b, required 0", ovf);
    end
    release dut.rx_valid;
    release dut.rx_data;
    release dut.tx_accept;
    do_reset();
    repeat (250) @(negedge clk);
    obs.delete();
    mon_en = 1'b1;
  endtask

  task automatic test_reset_midframe();
    bit found = 1'b0;
    logic [7:0] b;
    bit got;
    mode = 2'd0;
    for (int i = 0; i < 6; i++) send_byte(8'h20 + 8'(i));
    for (int i = 0; i < 400; i++) begin
      if (level === 3'd3) begin found = 1'b1; break; end
      @(negedge clk);
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL midframe_queue: level=%0d, required 3", level);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (tx !== 1'b1 || level !== 3'd0 || full !== 1'b0) begin
      tests_failed++;
      $display("FAIL midframe_async: tx=%b level=%0d full=%b, required 1/0/0", tx, level, full);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (250) @(negedge clk);
    obs.delete();
    expq.delete();
    expq.push_back(8'h7E);
    send_byte(8'h7E);
    wait_obs(b, got);
    tests_run++;
    if (!got || b !== expq[0]) begin
      tests_failed++;
      $display("FAIL midframe_loopback: got %h (seen=%0d), required %h", b, got, expq[0]);
    end
    void'(expq.pop_front());
    repeat (300) @(negedge clk);
    tests_run++;
    if (obs.size() != 0 || level !== 3'd0) begin
      tests_failed++;
      $display("FAIL midframe_extra: %0d extra bytes, level %0d, required 0/0", obs.size(), level);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic();
    test_transform();
    test_mode_switch();
    test_burst();
    test_full_corner();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
